// File: rtl/fwd_mux_pipe.sv
// ============================================================================
// Module   : fwd_mux_pipe
// Purpose  : Operand forwarding mux. Tracks the last DEPTH in-flight register
//            writes and picks the youngest match for the rs/rt operands.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fwd_mux_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 2,
  parameter int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              wr_valid,
  input  logic [REG_W-1:0]  wr_dst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_W-1:0]  rs_addr,
  input  logic [REG_W-1:0]  rt_addr,
  input  logic [DATA_W-1:0] rs_rf,
  input  logic [DATA_W-1:0] rt_rf,
  output logic [DATA_W-1:0] rs_out,
  output logic [DATA_W-1:0] rt_out,
  output logic [SEL_W-1:0]  rs_sel,
  output logic [SEL_W-1:0]  rt_sel
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [REG_W-1:0]  dst_q  [DEPTH];
  logic [REG_W-1:0]  dst_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  always_comb begin
    valid_d = valid_q;
    dst_d   = dst_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = '0;
    end else if (!stall) begin
      // $zero is never tracked, so a write to r0 enters as a bubble.
      valid_d[0] = wr_valid && (wr_dst != '0);
      dst_d[0]   = wr_dst;
      data_d[0]  = wr_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        dst_d[i]   = dst_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i]  <= dst_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  // Scan oldest to youngest so the youngest hit is the last one assigned.
  always_comb begin
    rs_out = rs_rf;
    rs_sel = '0;
    rt_out = rt_rf;
    rt_sel = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_q[k] && (rs_addr != '0) && (dst_q[k] == rs_addr)) begin
        rs_out = data_q[k];
        rs_sel = SEL_W'(k + 1);
      end
      if (valid_q[k] && (rt_addr != '0) && (dst_q[k] == rt_addr)) begin
        rt_out = data_q[k];
        rt_sel = SEL_W'(k + 1);
      end
    end
  end

endmodule

`default_nettype wire
